mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU in the 64-bit RISC-V datapath.
- Consumes the ALU result as the effective address for loads and stores. Passes it through unchanged for non-memory ops.
- Drives a valid/grant/response data-memory port, aligns and extends load data, and presents one result per instruction to writeback.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- LANES, XLEN/8, byte lanes on the data-memory bus; fixed at 8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; high only in IDLE.
- alu_res_i  in  64  ALU result; used as the address when a memory op is requested.
- store_data_i  in  64  rs2 value for stores.
- mem_read_i  in  1  instruction is a load.
- mem_write_i  in  1  instruction is a store; mem_read_i and mem_write_i are never both high.
- size_i  in  2  access size: 0=B, 1=H, 2=W, 3=D.
- unsigned_i  in  1  zero-extend load data (LBU/LHU/LWU).
- flush_i  in  1  kill the in-flight instruction.
- dmem_req_o  out  1  memory request; held high until granted.
- dmem_we_o  out  1  request is a write.
- dmem_addr_o  out  64  address, aligned to 8 bytes (addr[2:0]=0).
- dmem_wstrb_o  out  8  byte-lane write strobes.
- dmem_wdata_o  out  64  lane-aligned write data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  response or ack; exactly one per granted request, same cycle as gnt or later.
- dmem_rdata_i  in  64  read data, qualified by dmem_rvalid_i.
- wb_valid_o  out  1  one-cycle result strobe to writeback; writeback never back-pressures.
- wb_data_o  out  64  load data, ALU pass-through, or faulting address.
- misalign_o  out  1  misaligned access; qualified by wb_valid_o.

Behaviour:
- Reset values: state=IDLE; ready_o=1; dmem_req_o=0; wb_valid_o=0; misalign_o=0; wb_data_o=0; dmem_we_o=0; dmem_addr_o=0; dmem_wstrb_o=0; dmem_wdata_o=0.
- Reset mid-operation: the request drops immediately and the state returns to IDLE. A later stray dmem_rvalid_i in IDLE is ignored.
- Accept occurs when valid_i & ready_o. Address, size, unsigned, and store data are captured in registers at accept.

- States:
  - IDLE: accept an instruction.
    - No memory op: go to DONE with wb_data=alu_res_i.
    - Memory op with misaligned address: go to DONE with misalign=1 and wb_data=address. No request is issued.
    - Aligned memory op: go to REQ.
  - REQ: dmem_req_o=1 with stable addr/we/wstrb/wdata.
    - gnt & rvalid in the same cycle: go to DONE.
    - gnt only: go to WAIT.
  - WAIT: on rvalid, go to DONE.
  - DONE: wb_valid_o=1 for exactly one cycle, then go to IDLE. ready_o=0 in DONE.
  - DRAIN: absorb the single outstanding rvalid without writeback, then go to IDLE.

- Misalignment rules: H if addr[0]!=0; W if addr[1:0]!=0; D if addr[2:0]!=0; B is never misaligned.

- Latency:
  - Non-memory op or misaligned op: wb_valid_o one cycle after accept.
  - Memory op: wb_valid_o one cycle after the rvalid cycle.
  - Minimum memory-op latency is 2 cycles (gnt and rvalid in the cycle after accept).

- Store lanes:
  - wstrb = ((1<<(1<<size))-1) << addr[2:0].
  - wdata = store_data_i replicated per size: B×8, H×4, W×2, D×1.
- Loads: dmem_we_o=0 and wstrb=0.
- Load extract: shift rdata right by addr[2:0]*8, take the low 8/16/32/64 bits, then sign- or zero-extend per unsigned_i. For D, unsigned_i is ignored.
- Stores: wb_valid_o still pulses (ack) with wb_data_o=0. Writeback ignores it via its own rd=0 control.

- Flush:
  - In IDLE: an instruction presented in the same cycle is not accepted.
  - In REQ before gnt: drop the request and go to IDLE.
  - In REQ with gnt only: go to DRAIN.
  - In REQ with gnt & rvalid in the same cycle: go to IDLE without writeback.
  - In WAIT without rvalid: go to DRAIN. In WAIT with rvalid: go to IDLE without writeback.
  - In DONE: suppress wb_valid_o.

Decomposition:
- Shared package riscv_pkg:
  - mem_size_t enum: MEM_B, MEM_H, MEM_W, MEM_D.
  - mem_state_t enum: IDLE, REQ, WAIT, DONE, DRAIN.
  - XLEN constant, alongside the existing ALU OP_* constants.
- One combinational sub-module, load_align: inputs rdata, offset[2:0], size, unsigned; output the extended 64-bit value. The stage instantiates it once on the WAIT/REQ response path.

Test Plan:
- Non-memory op: alu_res_i=0x1234, no mem flags -> wb_valid_o next cycle, wb_data_o=0x1234, no dmem_req_o.
- LB: addr=0x1003, rdata=0x00000000_80000000 at the granted request, gnt and rvalid one cycle later -> wb_data_o=0xFFFFFFFF_FFFFFF80. LBU on the same data -> 0x80.
- SH: addr=0x1006, store_data=0xABCD -> dmem_addr_o=0x1000, wstrb=0xC0, wdata=0xABCDABCD_ABCDABCD. Hold req through 3 cycles of gnt=0 with all outputs stable.
- Misaligned LW: addr=0x1002 -> misalign_o=1, wb_data_o=0x1002, no request, ready_o back to 1 after two cycles.
- Flush in WAIT: after gnt, assert flush_i, rvalid arrives 2 cycles later -> no wb_valid_o, ready_o=0 until that rvalid cycle, then 1.
- Async reset: assert resetn=0 while in REQ -> dmem_req_o=0 immediately. A subsequent rvalid produces no wb_valid_o.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 datapath definitions: widths, ALU opcodes, memory-stage enums
// and the small lane/alignment helpers used by the memory stage.
package riscv_pkg;

  localparam int XLEN  = 64;
  localparam int LANES = XLEN / 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} mem_state_t;

  function automatic logic is_misaligned(logic [2:0] off, mem_size_t size);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return off[0];
      MEM_W:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

  // Byte strobes for an access of the given size starting at lane 'off'.
  function automatic logic [LANES-1:0] lane_mask(logic [2:0] off, mem_size_t size);
    logic [LANES-1:0] m;
    case (size)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] replicate(logic [XLEN-1:0] d, mem_size_t size);
    case (size)
      MEM_B:   return {8{d[7:0]}};
      MEM_H:   return {4{d[15:0]}};
      MEM_W:   return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: valid/grant request with a separate
// response strobe carrying read data or a store acknowledge.
interface mem_stage_if;
  import riscv_pkg::*;

  logic             dmem_req_o;
  logic             dmem_we_o;
  logic [XLEN-1:0]  dmem_addr_o;
  logic [LANES-1:0] dmem_wstrb_o;
  logic [XLEN-1:0]  dmem_wdata_o;
  logic             dmem_gnt_i;
  logic             dmem_rvalid_i;
  logic [XLEN-1:0]  dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load-data aligner: picks the addressed bytes out of a 64-bit memory word
// and sign- or zero-extends them to the full register width.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (size)
      MEM_B:   data = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      MEM_H:   data = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   data = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues one data-memory access per load/store,
// aligns load data and hands exactly one result per instruction to writeback.
module mem_stage #(
  parameter int XLEN  = 64,
  parameter int LANES = XLEN / 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  alu_res_i,
  input  logic [XLEN-1:0]  store_data_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic             flush_i,
  mem_stage_if.master      dmem,
  output logic             wb_valid_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             misalign_o
);
  import riscv_pkg::*;

  mem_state_t       state, state_next;
  mem_size_t        size_in, size_q;
  logic             accept, is_mem, misaligned, resp;
  logic             unsigned_q, we_q, misalign_q;
  logic [XLEN-1:0]  addr_q, wdata_q, wb_data_q, load_data;
  logic [LANES-1:0] wstrb_q;

  assign size_in    = mem_size_t'(size_i);
  assign is_mem     = mem_read_i | mem_write_i;
  assign misaligned = is_mem & is_misaligned(alu_res_i[2:0], size_in);
  assign accept     = valid_i & ready_o & ~flush_i;
  assign resp       = dmem.dmem_rvalid_i &
                      (((state == REQ) & dmem.dmem_gnt_i) | (state == WAIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // A flushed access that was already granted still owes us one rvalid;
  // DRAIN swallows it so it cannot be mistaken for the next instruction's.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (is_mem && !misaligned) ? REQ : DONE;
      REQ: begin
        if (flush_i) begin
          if (dmem.dmem_gnt_i && !dmem.dmem_rvalid_i) state_next = DRAIN;
          else                                        state_next = IDLE;
        end else if (dmem.dmem_gnt_i) begin
          state_next = dmem.dmem_rvalid_i ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid_i) state_next = flush_i ? IDLE : DONE;
        else if (flush_i)       state_next = DRAIN;
      end
      DONE:  state_next = IDLE;
      DRAIN: if (dmem.dmem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o         = (state == IDLE);
    dmem.dmem_req_o = (state == REQ);
    wb_valid_o      = (state == DONE) & ~flush_i;
  end

  // Address is the ALU result, so it doubles as the pass-through value and
  // the faulting address; an aligned access overwrites it on response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      size_q     <= MEM_B;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      wb_data_q  <= '0;
    end else if (accept) begin
      addr_q     <= alu_res_i;
      size_q     <= size_in;
      unsigned_q <= unsigned_i;
      we_q       <= mem_write_i;
      wstrb_q    <= mem_write_i ? lane_mask(alu_res_i[2:0], size_in) : '0;
      wdata_q    <= replicate(store_data_i, size_in);
      misalign_q <= misaligned;
      wb_data_q  <= alu_res_i;
    end else if (resp) begin
      wb_data_q  <= we_q ? '0 : load_data;
    end
  end

  load_align u_load_align (
    .rdata       (dmem.dmem_rdata_i),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (load_data)
  );

  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
  assign dmem.dmem_wstrb_o = wstrb_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign wb_data_o         = wb_data_q;
  assign misalign_o        = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: the bench plays the data memory cycle by
// cycle and compares every output against hand-computed values.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [63:0] alu_res;
  logic [63:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        uns;
  logic        flush;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  mem_stage_if dmem ();

  mem_stage #(.XLEN(64), .LANES(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .valid_i      (valid),
    .ready_o      (ready),
    .alu_res_i    (alu_res),
    .store_data_i (store_data),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .size_i       (size),
    .unsigned_i   (uns),
    .flush_i      (flush),
    .dmem         (dmem),
    .wb_valid_o   (wb_valid),
    .wb_data_o    (wb_data),
    .misalign_o   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load vectors: address, size, unsigned, memory word, expected result.
  logic [63:0] ld_addr  [7] = '{64'h1003, 64'h1003, 64'h1002, 64'h1002, 64'h1004, 64'h1004, 64'h1008};
  logic [1:0]  ld_size  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  logic        ld_uns   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [63:0] ld_rdata [7] = '{64'h00000000_80000000, 64'h00000000_80000000,
                                64'h00000000_F00D0000, 64'h00000000_F00D0000,
                                64'h80000001_00000000, 64'h80000001_00000000,
                                64'h80000000_00000001};
  logic [63:0] ld_exp   [7] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_00000080,
                                64'h00000000_0000F00D, 64'hFFFFFFFF_FFFFF00D,
                                64'hFFFFFFFF_80000001, 64'h00000000_80000001,
                                64'h80000000_00000001};

  // Store vectors: address, data, size, strobe, lane data, stall cycles.
  logic [63:0] st_addr  [4] = '{64'h1006, 64'h1005, 64'h1004, 64'h1008};
  logic [63:0] st_data  [4] = '{64'hFFFF0000_0000ABCD, 64'h00000000_0000005A,
                                64'hDEADBEEF_11223344, 64'h01234567_89ABCDEF};
  logic [1:0]  st_size  [4] = '{2'd1, 2'd0, 2'd2, 2'd3};
  logic [7:0]  st_strb  [4] = '{8'hC0, 8'h20, 8'hF0, 8'hFF};
  logic [63:0] st_wdata [4] = '{64'hABCDABCD_ABCDABCD, 64'h5A5A5A5A_5A5A5A5A,
                                64'h11223344_11223344, 64'h01234567_89ABCDEF};
  int          st_stall [4] = '{3, 0, 1, 0};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    flush      = 1'b0;
    dmem.dmem_gnt_i    = 1'b0;
    dmem.dmem_rvalid_i = 1'b0;
  endtask

  task automatic issue(input logic [63:0] addr, input logic [63:0] sd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic u);
    valid      = 1'b1;
    alu_res    = addr;
    store_data = sd;
    mem_read   = rd;
    mem_write  = wr;
    size       = sz;
    uns        = u;
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0h exp=1", ready); end
    checks++; if ({dmem.dmem_req_o, wb_valid, misalign, dmem.dmem_we_o} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_ctrl got=%b exp=0000", {dmem.dmem_req_o, wb_valid, misalign, dmem.dmem_we_o}); end
    checks++; if ({wb_data, dmem.dmem_addr_o, dmem.dmem_wstrb_o, dmem.dmem_wdata_o} !== 200'b0) begin
      failures++; $display("[TB] FAIL reset_data got=%h exp=0", {wb_data, dmem.dmem_addr_o, dmem.dmem_wstrb_o, dmem.dmem_wdata_o}); end
  endtask

  task automatic test_non_mem();
    next_cycle(); issue(64'h1234, 64'h0, 1'b0, 1'b0, 2'd3, 1'b0); settle();
    checks++; if (dmem.dmem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL nonmem_req got=%0h exp=0", dmem.dmem_req_o); end
    next_cycle(); idle_inputs(); settle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h1234) begin
      failures++; $display("[TB] FAIL nonmem_wb got=%0h/%h exp=1/1234", wb_valid, wb_data); end
    checks++; if ({ready, dmem.dmem_req_o, misalign} !== 3'b000) begin
      failures++; $display("[TB] FAIL nonmem_done_ctrl got=%b exp=000", {ready, dmem.dmem_req_o, misalign}); end
    next_cycle(); settle();
    checks++; if (wb_valid !== 1'b0 || ready !== 1'b1) begin
      failures++; $display("[TB] FAIL nonmem_idle got=%0h/%0h exp=0/1", wb_valid, ready); end
  endtask

  task automatic test_loads();
    for (int i = 0; i < 7; i++) begin
      next_cycle(); issue(ld_addr[i], 64'h0, 1'b1, 1'b0, ld_size[i], ld_uns[i]); settle();
      next_cycle(); idle_inputs();
      dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = ld_rdata[i]; settle();
      checks++; if ({dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wstrb_o} !== {2'b10, ld_addr[i] & ~64'h7, 8'h00}) begin
        failures++; $display("[TB] FAIL load%0d_req got=%h exp=%h", i,
          {dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wstrb_o}, {2'b10, ld_addr[i] & ~64'h7, 8'h00}); end
      next_cycle(); idle_inputs(); dmem.dmem_rdata_i = 64'hDEADBEEF_DEADBEEF; settle();
      checks++; if (wb_valid !== 1'b1 || wb_data !== ld_exp[i] || misalign !== 1'b0) begin
        failures++; $display("[TB] FAIL load%0d_wb got=%0h/%h/%0h exp=1/%h/0", i, wb_valid, wb_data, misalign, ld_exp[i]); end
      next_cycle(); settle();
      checks++; if (wb_valid !== 1'b0 || ready !== 1'b1) begin
        failures++; $display("[TB] FAIL load%0d_idle got=%0h/%0h exp=0/1", i, wb_valid, ready); end
    end
  endtask

  task automatic test_stores();
    logic [137:0] exp_bus;
    for (int i = 0; i < 4; i++) begin
      exp_bus = {2'b11, st_addr[i] & ~64'h7, st_strb[i], st_wdata[i]};
      next_cycle(); issue(st_addr[i], st_data[i], 1'b0, 1'b1, st_size[i], 1'b0); settle();
      for (int s = 0; s <= st_stall[i]; s++) begin
        next_cycle(); idle_inputs(); store_data = 64'h0;
        dmem.dmem_gnt_i = (s == st_stall[i]); settle();
        checks++; if ({dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wstrb_o, dmem.dmem_wdata_o} !== exp_bus) begin
          failures++; $display("[TB] FAIL store%0d_bus_c%0d got=%h exp=%h", i, s,
            {dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wstrb_o, dmem.dmem_wdata_o}, exp_bus); end
      end
      next_cycle(); idle_inputs(); dmem.dmem_rvalid_i = 1'b1; settle();
      checks++; if ({dmem.dmem_req_o, ready, wb_valid} !== 3'b000) begin
        failures++; $display("[TB] FAIL store%0d_wait got=%b exp=000", i, {dmem.dmem_req_o, ready, wb_valid}); end
      next_cycle(); idle_inputs(); settle();
      checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h0) begin
        failures++; $display("[TB] FAIL store%0d_ack got=%0h/%h exp=1/0", i, wb_valid, wb_data); end
      next_cycle(); settle();
      checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL store%0d_idle got=%0h exp=1", i, ready); end
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] m_addr [3] = '{64'h1002, 64'h1001, 64'h100C};
    logic [1:0]  m_size [3] = '{2'd2, 2'd1, 2'd3};
    logic        m_wr   [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      next_cycle(); issue(m_addr[i], 64'h77, ~m_wr[i], m_wr[i], m_size[i], 1'b0); settle();
      next_cycle(); idle_inputs(); settle();
      checks++; if ({wb_valid, misalign, dmem.dmem_req_o, ready} !== 4'b1100 || wb_data !== m_addr[i]) begin
        failures++; $display("[TB] FAIL misalign%0d got=%b/%h exp=1100/%h", i,
          {wb_valid, misalign, dmem.dmem_req_o, ready}, wb_data, m_addr[i]); end
      next_cycle(); settle();
      checks++; if (ready !== 1'b1 || dmem.dmem_req_o !== 1'b0) begin
        failures++; $display("[TB] FAIL misalign%0d_idle got=%0h/%0h exp=1/0", i, ready, dmem.dmem_req_o); end
    end
  endtask

  task automatic test_flush_wait();
    next_cycle(); issue(64'h2000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0); settle();
    next_cycle(); idle_inputs(); dmem.dmem_gnt_i = 1'b1; settle();
    checks++; if (dmem.dmem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL fwait_req got=%0h exp=1", dmem.dmem_req_o); end
    next_cycle(); idle_inputs(); flush = 1'b1; settle();
    checks++; if ({ready, wb_valid} !== 2'b00) begin failures++; $display("[TB] FAIL fwait_flush got=%b exp=00", {ready, wb_valid}); end
    next_cycle(); idle_inputs(); settle();
    checks++; if ({ready, wb_valid, dmem.dmem_req_o} !== 3'b000) begin
      failures++; $display("[TB] FAIL fwait_drain got=%b exp=000", {ready, wb_valid, dmem.dmem_req_o}); end
    next_cycle(); dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 64'h1; settle();
    checks++; if ({ready, wb_valid} !== 2'b00) begin failures++; $display("[TB] FAIL fwait_rvalid got=%b exp=00", {ready, wb_valid}); end
    next_cycle(); idle_inputs(); settle();
    checks++; if ({ready, wb_valid} !== 2'b10) begin failures++; $display("[TB] FAIL fwait_idle got=%b exp=10", {ready, wb_valid}); end
    next_cycle(); settle();
    checks++; if ({ready, wb_valid} !== 2'b10) begin failures++; $display("[TB] FAIL fwait_after got=%b exp=10", {ready, wb_valid}); end
  endtask

  task automatic test_flush_req();
    // mode 0: no grant, mode 1: grant and rvalid together, mode 2: grant only
    for (int mode = 0; mode < 3; mode++) begin
      next_cycle(); issue(64'h3008, 64'h0, 1'b1, 1'b0, 2'd2, 1'b0); settle();
      next_cycle(); idle_inputs(); flush = 1'b1;
      dmem.dmem_gnt_i = (mode != 0); dmem.dmem_rvalid_i = (mode == 1); settle();
      next_cycle(); idle_inputs(); settle();
      checks++; if ({ready, wb_valid, dmem.dmem_req_o} !== ((mode == 2) ? 3'b000 : 3'b100)) begin
        failures++; $display("[TB] FAIL freq%0d_after got=%b exp=%b", mode,
          {ready, wb_valid, dmem.dmem_req_o}, (mode == 2) ? 3'b000 : 3'b100); end
      if (mode == 2) begin
        dmem.dmem_rvalid_i = 1'b1;
        next_cycle(); idle_inputs(); settle();
        checks++; if ({ready, wb_valid} !== 2'b10) begin failures++; $display("[TB] FAIL freq2_drain got=%b exp=10", {ready, wb_valid}); end
      end
    end
  endtask

  task automatic test_flush_idle_done();
    next_cycle(); issue(64'h55, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0); flush = 1'b1; settle();
    next_cycle(); idle_inputs(); settle();
    checks++; if ({ready, wb_valid} !== 2'b10) begin failures++; $display("[TB] FAIL fidle got=%b exp=10", {ready, wb_valid}); end
    next_cycle(); issue(64'h66, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0); settle();
    next_cycle(); idle_inputs(); flush = 1'b1; settle();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("[TB] FAIL fdone got=%0h exp=0", wb_valid); end
    next_cycle(); idle_inputs(); settle();
    checks++; if ({ready, wb_valid} !== 2'b10) begin failures++; $display("[TB] FAIL fdone_idle got=%b exp=10", {ready, wb_valid}); end
  endtask

  task automatic test_back_to_back();
    next_cycle(); issue(64'hA, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0); settle();
    next_cycle(); alu_res = 64'hB; settle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hA || ready !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_first got=%0h/%h/%0h exp=1/a/0", wb_valid, wb_data, ready); end
    next_cycle(); alu_res = 64'hC; settle();
    checks++; if (wb_valid !== 1'b0 || ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_gap got=%0h/%0h exp=0/1", wb_valid, ready); end
    next_cycle(); idle_inputs(); settle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hC) begin
      failures++; $display("[TB] FAIL b2b_second got=%0h/%h exp=1/c", wb_valid, wb_data); end
    next_cycle(); settle();
  endtask

  task automatic test_async_reset();
    next_cycle(); issue(64'h4000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0); settle();
    next_cycle(); idle_inputs(); settle();
    checks++; if (dmem.dmem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre got=%0h exp=1", dmem.dmem_req_o); end
    #1 resetn = 1'b0;
    #1;
    checks++; if ({dmem.dmem_req_o, ready, wb_valid} !== 3'b010) begin
      failures++; $display("[TB] FAIL areset_drop got=%b exp=010", {dmem.dmem_req_o, ready, wb_valid}); end
    settle(); resetn = 1'b1;
    next_cycle(); dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 64'h99; settle();
    checks++; if ({wb_valid, ready, dmem.dmem_req_o} !== 3'b010) begin
      failures++; $display("[TB] FAIL areset_stray got=%b exp=010", {wb_valid, ready, dmem.dmem_req_o}); end
    next_cycle(); idle_inputs(); settle();
    checks++; if ({wb_valid, ready} !== 2'b01) begin failures++; $display("[TB] FAIL areset_after got=%b exp=01", {wb_valid, ready}); end
  endtask

  initial begin
    resetn     = 1'b1;
    alu_res    = '0;
    store_data = '0;
    size       = 2'd0;
    uns        = 1'b0;
    dmem.dmem_rdata_i = '0;
    idle_inputs();
    #1 resetn = 1'b0;
    #11;
    test_reset();
    settle();
    resetn = 1'b1;
    test_non_mem();
    test_loads();
    test_stores();
    test_misaligned();
    test_flush_wait();
    test_flush_req();
    test_flush_idle_done();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
